// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the parallel-in/serial-out transmitter
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_t;

  // Counter width with a floor of one bit so DIV=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_period_counter.sv
// rtl/piso_serializer_bit_period_counter.sv - counts clock cycles within one bit period
module bit_period_counter
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (DIV == 1 || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

  assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel word in, one qualified serial bit per bit period out
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_data,
  output logic             ser_shift_enable,
  output logic             busy,
  output logic             frame_done
);

  localparam int BCW = $clog2(WIDTH);

  piso_state_t      state;
  logic [WIDTH-1:0] shift_reg;
  logic [BCW-1:0]   bit_cnt;
  logic             tick;
  logic             last_bit;
  logic             load;

  bit_period_counter #(.DIV(DIV)) u_bit_period_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .clr     (load),
    .tick    (tick)
  );

  assign busy             = (state == SHIFT);
  assign ser_shift_enable = busy && tick;
  assign last_bit         = ser_shift_enable && (bit_cnt == BCW'(WIDTH - 1));
  // Ready opens in the final cycle of the final bit so streaming words leave no gap.
  assign tx_ready         = (state == IDLE) || last_bit;
  assign load             = tx_valid && tx_ready;
  assign ser_data         = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_bit;
      if (load) begin
        shift_reg <= tx_data;
        bit_cnt   <= '0;
        state     <= SHIFT;
      end else if (ser_shift_enable) begin
        shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
        if (last_bit) begin
          bit_cnt <= '0;
          state   <= IDLE;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data = '0, tx_data4 = '0, tx_data_l = '0;
  logic tx_valid = 1'b0, tx_valid4 = 1'b0, tx_valid_l = 1'b0;
  logic tx_ready, ser_data, ser_en, busy, frame_done;
  logic tx_ready4, ser_data4, ser_en4, busy4, frame_done4;
  logic tx_ready_l, ser_data_l, ser_en_l, busy_l, frame_done_l;

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_data(ser_data), .ser_shift_enable(ser_en),
    .busy(busy), .frame_done(frame_done));

  piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) dut_d4 (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready4), .ser_data(ser_data4), .ser_shift_enable(ser_en4),
    .busy(busy4), .frame_done(frame_done4));

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
    .tx_ready(tx_ready_l), .ser_data(ser_data_l), .ser_shift_enable(ser_en_l),
    .busy(busy_l), .frame_done(frame_done_l));

  // Loopback receivers: MSB-first links shift in at the LSB, LSB-first at the MSB.
  logic [7:0] rx = '0, rx4 = '0, rx_l = '0;
  always @(posedge clk) begin
    if (ser_en)   rx   <= {rx[6:0], ser_data};
    if (ser_en4)  rx4  <= {rx4[6:0], ser_data4};
    if (ser_en_l) rx_l <= {ser_data_l, rx_l[7:1]};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w;
  int ens;

  initial begin
    // Reset state
    step();
    check("rst_ser_data", ser_data, 0);
    check("rst_en", ser_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    reset_n = 1'b1;
    step();
    check("rst_tx_ready", tx_ready, 1);

    // A5, DIV=1, MSB first
    w = 8'hA5;
    tx_data = w; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_bit%0d", i), ser_data, w[7-i]);
      check($sformatf("a5_en%0d", i), ser_en, 1);
      check($sformatf("a5_rdy%0d", i), tx_ready, (i == 7));
      check($sformatf("a5_fd%0d", i), frame_done, 0);
      step();
    end
    check("a5_frame_done", frame_done, 1);
    check("a5_busy_end", busy, 0);
    check("a5_rx", rx, 8'hA5);
    step();
    check("a5_fd_pulse", frame_done, 0);

    // 3C then FF streamed back to back
    tx_data = 8'h3C; tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? 8'h3C : 8'hFF;
      check($sformatf("bb_en%0d", i), ser_en, 1);
      check($sformatf("bb_bit%0d", i), ser_data, w[7-(i%8)]);
      check($sformatf("bb_rdy%0d", i), tx_ready, (i % 8 == 7));
      check($sformatf("bb_fd%0d", i), frame_done, (i == 8));
      check($sformatf("bb_busy%0d", i), busy, 1);
      if (i == 8) check("bb_rx_first", rx, 8'h3C);
      step();
      if (i == 7) tx_valid = 1'b0;
    end
    check("bb_fd_last", frame_done, 1);
    check("bb_rx_second", rx, 8'hFF);
    check("bb_idle", busy, 0);

    // 81 at DIV=4
    w = 8'h81;
    tx_data4 = w; tx_valid4 = 1'b1;
    step();
    tx_valid4 = 1'b0;
    ens = 0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("d4_en%0d", i), ser_en4, (i % 4 == 3));
      check($sformatf("d4_bit%0d", i), ser_data4, w[7-(i/4)]);
      check($sformatf("d4_busy%0d", i), busy4, 1);
      if (ser_en4) ens++;
      step();
    end
    check("d4_enables", ens, 8);
    check("d4_frame_done", frame_done4, 1);
    check("d4_rx", rx4, 8'h81);

    // Reset after three bits of F0
    tx_data = 8'hF0; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_ser_data", ser_data, 0);
    check("mid_rst_en", ser_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fd", frame_done, 0);
    step();
    reset_n = 1'b1;
    check("mid_rst_rdy", tx_ready, 1);
    ens = 0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("mid_rst_nofd%0d", i), frame_done, 0);
      if (ser_en) ens++;
      step();
    end
    check("mid_rst_no_en", ens, 0);
    tx_data = 8'h55; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    ens = 0;
    for (int i = 0; i < 12; i++) begin
      if (ser_en) ens++;
      step();
    end
    check("post_rst_enables", ens, 8);
    check("post_rst_rx", rx, 8'h55);

    // LSB first, tx_data changed after handshake
    tx_data_l = 8'h01; tx_valid_l = 1'b1;
    step();
    tx_valid_l = 1'b0; tx_data_l = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb_bit%0d", i), ser_data_l, (i == 0));
      check($sformatf("lsb_en%0d", i), ser_en_l, 1);
      step();
    end
    check("lsb_frame_done", frame_done_l, 1);
    check("lsb_rx", rx_l, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
